// File: rtl/cia_timer_array.sv
// rtl/cia_timer_array.sv - CIA-style array of cascadable interval timers
//
// Purpose: CHANNELS independent WIDTH-bit down-counters behind one CIA-style
//   chip-select/rs bus port, with a shared interrupt control register (ICR).
//   Each channel counts system clocks, cnt_in rising edges, or underflows of
//   the previous channel (optionally gated by the cnt_in level).
//
// Parameters:
//   CHANNELS  number of timers, 1..7
//   WIDTH     counter width, 8/16/24/32
//   ADDR_W    rs width, 2**ADDR_W > CHANNELS*8
//
// Ports:
//   clk            system clock, all state on posedge
//   res            asynchronous active-high reset
//   cs_n, rw, rs   bus strobe (active low), 1=write/0=read, register select
//   db_in, db_out  write data, registered read data
//   cnt_in         asynchronous external count pin
//   pb_out         per-channel timer outputs
//   irq_n          interrupt request, active low
//
// Register map (channel c base = c*8):
//   +0..+WIDTH/8-1  write latch byte / read counter byte
//   +4              CTRL {0, SRC[1:0], LOAD, ONESHOT, TOGGLE, PBON, START}
//   CHANNELS*8      ICR
//
// Optional build macro CIA_TMR_SNAPSHOT_EN: a read of counter byte 0 captures
//   the whole counter; reads of the upper bytes then return that capture.
module cia_timer_array #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 6
) (
  input  logic                clk,
  input  logic                res,
  input  logic                cs_n,
  input  logic                rw,
  input  logic [ADDR_W-1:0]   rs,
  input  logic [7:0]          db_in,
  output logic [7:0]          db_out,
  input  logic                cnt_in,
  output logic [CHANNELS-1:0] pb_out,
  output logic                irq_n
);

  localparam int NB = WIDTH / 8;
  localparam logic [ADDR_W-1:0] ICR_ADDR = ADDR_W'(CHANNELS * 8);

  // Per-channel state
  logic [WIDTH-1:0]    latch_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_q   [CHANNELS];
  logic [1:0]          src_q   [CHANNELS];
  logic [CHANNELS-1:0] start_q;
  logic [CHANNELS-1:0] pbon_q;
  logic [CHANNELS-1:0] tmode_q;
  logic [CHANNELS-1:0] oneshot_q;
  logic [CHANNELS-1:0] tff_q;
  logic [CHANNELS-1:0] pulse_q;

`ifdef CIA_TMR_SNAPSHOT_EN
  logic [WIDTH-1:0]    snap_q  [CHANNELS];
`endif

  // Shared interrupt state
  logic [CHANNELS-1:0] flag_q;
  logic [CHANNELS-1:0] imr_q;

  // cnt_in synchroniser and edge detector
  logic cnt_s1, cnt_s2, cnt_s3;

  // Decoded strobes and per-channel combinational results
  logic                wr_en, rd_en;
  logic                icr_rd, icr_wr;
  logic                cnt_rise, cnt_lvl;
  logic [CHANNELS-1:0] ctrl_wr;
  logic [CHANNELS-1:0] force_ld;
  logic [CHANNELS-1:0] msb_ld;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] uf;
  logic [WIDTH-1:0]    latch_nxt [CHANNELS];
  logic [7:0]          rd_data;

  assign wr_en    = ~cs_n & rw;
  assign rd_en    = ~cs_n & ~rw;
  assign icr_rd   = rd_en && (rs == ICR_ADDR);
  assign icr_wr   = wr_en && (rs == ICR_ADDR);
  assign cnt_rise = cnt_s2 & ~cnt_s3;
  assign cnt_lvl  = cnt_s2;

  // Channel evaluation. Channels are walked in order so the underflow of
  // channel c-1 is available to channel c in the same cycle; a full cascade
  // chain therefore resolves combinationally within one clock.
  always_comb begin
    logic prev_uf;
    logic src_act;
    prev_uf  = 1'b0;
    src_act  = 1'b0;
    ctrl_wr  = '0;
    force_ld = '0;
    msb_ld   = '0;
    tick     = '0;
    uf       = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ctrl_wr[c]  = wr_en && (rs == ADDR_W'(c * 8 + 4));
      force_ld[c] = ctrl_wr[c] && db_in[4];
      // Top latch byte written while stopped also primes the counter.
      msb_ld[c]   = wr_en && (rs == ADDR_W'(c * 8 + NB - 1)) && !start_q[c];

      latch_nxt[c] = latch_q[c];
      for (int k = 0; k < NB; k++) begin
        if (wr_en && (rs == ADDR_W'(c * 8 + k))) begin
          latch_nxt[c][8*k +: 8] = db_in;
        end
      end

      // Channel 0 has no predecessor: cascade sources fall back to the
      // plain clock / cnt_in edge sources.
      case (src_q[c])
        2'b00:   src_act = 1'b1;
        2'b01:   src_act = cnt_rise;
        2'b10:   src_act = (c == 0) ? 1'b1 : prev_uf;
        default: src_act = (c == 0) ? cnt_rise : (prev_uf & cnt_lvl);
      endcase

      tick[c] = start_q[c] && src_act;
      // A force load on this edge wins over the tick entirely.
      uf[c]   = tick[c] && (cnt_q[c] == '0) && !force_ld[c];
      prev_uf = uf[c];
    end
  end

  // Read data mux, sampled into db_out on the read edge.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < NB; k++) begin
        if (rs == ADDR_W'(c * 8 + k)) begin
`ifdef CIA_TMR_SNAPSHOT_EN
          rd_data = (k == 0) ? cnt_q[c][7:0] : snap_q[c][8*k +: 8];
`else
          rd_data = cnt_q[c][8*k +: 8];
`endif
        end
      end
      if (rs == ADDR_W'(c * 8 + 4)) begin
        rd_data = {1'b0, src_q[c], 1'b0, oneshot_q[c], tmode_q[c],
                   pbon_q[c], start_q[c]};
      end
    end
    if (rs == ICR_ADDR) begin
      rd_data[7]            = ~irq_n;
      rd_data[CHANNELS-1:0] = flag_q;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int c = 0; c < CHANNELS; c++) begin
        latch_q[c] <= '1;
        cnt_q[c]   <= '0;
        src_q[c]   <= '0;
`ifdef CIA_TMR_SNAPSHOT_EN
        snap_q[c]  <= '0;
`endif
      end
      start_q   <= '0;
      pbon_q    <= '0;
      tmode_q   <= '0;
      oneshot_q <= '0;
      tff_q     <= '0;
      pulse_q   <= '0;
      flag_q    <= '0;
      imr_q     <= '0;
      cnt_s1    <= 1'b0;
      cnt_s2    <= 1'b0;
      cnt_s3    <= 1'b0;
      db_out    <= '0;
      irq_n     <= 1'b1;
    end else begin
      cnt_s1  <= cnt_in;
      cnt_s2  <= cnt_s1;
      cnt_s3  <= cnt_s2;
      pulse_q <= uf;

      for (int c = 0; c < CHANNELS; c++) begin
        latch_q[c] <= latch_nxt[c];

        // Later assignments below take priority: force load > top-byte
        // prime > underflow reload / decrement.
        if (uf[c]) begin
          cnt_q[c] <= latch_q[c];
          tff_q[c] <= ~tff_q[c];
          if (oneshot_q[c]) begin
            start_q[c] <= 1'b0;
          end
        end else if (tick[c]) begin
          cnt_q[c] <= cnt_q[c] - WIDTH'(1);
        end

        if (msb_ld[c]) begin
          cnt_q[c] <= latch_nxt[c];
        end
        if (force_ld[c]) begin
          cnt_q[c] <= latch_q[c];
        end

        if (ctrl_wr[c]) begin
          start_q[c]   <= db_in[0];
          pbon_q[c]    <= db_in[1];
          tmode_q[c]   <= db_in[2];
          oneshot_q[c] <= db_in[3];
          src_q[c]     <= db_in[6:5];
          // Starting a stopped timer always begins the toggle output high.
          if (!start_q[c] && db_in[0]) begin
            tff_q[c] <= 1'b1;
          end
        end

`ifdef CIA_TMR_SNAPSHOT_EN
        if (rd_en && (rs == ADDR_W'(c * 8))) begin
          snap_q[c] <= cnt_q[c];
        end
`endif
      end

      // An ICR read clears every flag, but an underflow on that same edge
      // re-sets its flag so the event is not lost.
      if (icr_rd) begin
        flag_q <= uf;
        irq_n  <= 1'b1;
      end else begin
        flag_q <= flag_q | uf;
        if (|(flag_q & imr_q)) begin
          irq_n <= 1'b0;
        end
      end

      if (icr_wr) begin
        if (db_in[7]) begin
          imr_q <= imr_q | db_in[CHANNELS-1:0];
        end else begin
          imr_q <= imr_q & ~db_in[CHANNELS-1:0];
        end
      end

      db_out <= rd_en ? rd_data : 8'h00;
    end
  end

  // Timer outputs: toggle flop or one-clock underflow pulse, gated by PBON.
  always_comb begin
    pb_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pb_out[c] = pbon_q[c] & (tmode_q[c] ? tff_q[c] : pulse_q[c]);
    end
  end

endmodule

// File: tb/tb_cia_timer_array.sv
// tb/tb_cia_timer_array.sv - directed self-checking bench for cia_timer_array
module tb_cia_timer_array;

  localparam int CHANNELS = 2;
  localparam int WIDTH    = 16;
  localparam int ADDR_W   = 6;

  logic                clk = 1'b0;
  logic                res;
  logic                cs_n;
  logic                rw;
  logic [ADDR_W-1:0]   rs;
  logic [7:0]          db_in;
  logic [7:0]          db_out;
  logic                cnt_in;
  logic [CHANNELS-1:0] pb_out;
  logic                irq_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cia_timer_array #(
    .CHANNELS(CHANNELS),
    .WIDTH   (WIDTH),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk   (clk),
    .res   (res),
    .cs_n  (cs_n),
    .rw    (rw),
    .rs    (rs),
    .db_in (db_in),
    .db_out(db_out),
    .cnt_in(cnt_in),
    .pb_out(pb_out),
    .irq_n (irq_n)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    cs_n = 1'b0; rw = 1'b1; rs = a; db_in = d;
    @(negedge clk);
    cs_n = 1'b1; rw = 1'b0; rs = '0; db_in = '0;
  endtask

  task automatic bus_rd(input logic [ADDR_W-1:0] a, output logic [7:0] d);
    cs_n = 1'b0; rw = 1'b0; rs = a;
    @(negedge clk);
    d = db_out;
    cs_n = 1'b1; rs = '0;
  endtask

  task automatic do_reset;
    res = 1'b1;
    step(2);
    res = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    res = 1'b1; cs_n = 1'b1; rw = 1'b0; rs = '0; db_in = '0; cnt_in = 1'b0;
    step(2);
    n_cmp++; if (db_out !== 8'h00) begin n_bad++; $display("FAIL rst_db_out: got %h expected 00", db_out); end
    n_cmp++; if (pb_out !== 2'b00) begin n_bad++; $display("FAIL rst_pb_out: got %b expected 00", pb_out); end
    n_cmp++; if (irq_n !== 1'b1) begin n_bad++; $display("FAIL rst_irq_n: got %b expected 1", irq_n); end
    res = 1'b0;
    step(1);
    bus_rd(6'd0, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rst_cnt0: got %h expected 00", d); end
    bus_rd(6'd4, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rst_ctrl0: got %h expected 00", d); end
    bus_rd(6'd16, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rst_icr: got %h expected 00", d); end
  endtask

  task automatic test_periodic_irq;
    logic [7:0] d;
    bit found;
    int per;
    do_reset();
    bus_wr(6'd0, 8'h03);
    bus_wr(6'd1, 8'h00);
    bus_wr(6'd16, 8'h81);
    bus_wr(6'd4, 8'h01);
    step(4);
    n_cmp++; if (irq_n !== 1'b1) begin n_bad++; $display("FAIL irq_n_before: got %b expected 1", irq_n); end
    step(1);
    n_cmp++; if (irq_n !== 1'b0) begin n_bad++; $display("FAIL irq_n_assert: got %b expected 0", irq_n); end
    bus_rd(6'd16, d);
    n_cmp++; if (d !== 8'h81) begin n_bad++; $display("FAIL icr_read: got %h expected 81", d); end
    n_cmp++; if (irq_n !== 1'b1) begin n_bad++; $display("FAIL irq_n_cleared: got %b expected 1", irq_n); end
    bus_rd(6'd16, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL icr_reread: got %h expected 00", d); end
    bus_wr(6'd4, 8'h03);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin step(1); if (pb_out[0]) found = 1; end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL ch0_pulse_seen: got none expected pulse within 10 clk"); end
    per = 0; found = 0;
    for (int i = 1; i <= 10 && !found; i++) begin step(1); if (pb_out[0]) begin found = 1; per = i; end end
    n_cmp++; if (per !== 4) begin n_bad++; $display("FAIL ch0_period: got %0d expected 4", per); end
  endtask

  task automatic test_cascade;
    logic [7:0] d;
    bit found;
    logic prev;
    int per, hi;
    do_reset();
    bus_wr(6'd0, 8'h01);
    bus_wr(6'd1, 8'h00);
    bus_wr(6'd8, 8'h02);
    bus_wr(6'd9, 8'h00);
    bus_wr(6'd12, 8'h43);
    bus_wr(6'd4, 8'h01);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin step(1); if (pb_out[1]) found = 1; end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL ch1_pulse_seen: got none expected pulse within 20 clk"); end
    per = 0; found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin step(1); if (pb_out[1]) begin found = 1; per = i; end end
    n_cmp++; if (per !== 6) begin n_bad++; $display("FAIL ch1_cascade_period: got %0d expected 6", per); end
    bus_wr(6'd12, 8'h47);
    bus_rd(6'd12, d);
    n_cmp++; if (d !== 8'h47) begin n_bad++; $display("FAIL ch1_ctrl_readback: got %h expected 47", d); end
    prev = pb_out[1]; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin step(1); if (pb_out[1] && !prev) found = 1; prev = pb_out[1]; end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL ch1_toggle_rise: got none expected rise within 40 clk"); end
    per = 0; hi = 1; found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      step(1);
      if (pb_out[1] && !prev) begin found = 1; per = i; end
      else if (pb_out[1]) hi++;
      prev = pb_out[1];
    end
    n_cmp++; if (per !== 12) begin n_bad++; $display("FAIL ch1_toggle_period: got %0d expected 12", per); end
    n_cmp++; if (hi !== 6) begin n_bad++; $display("FAIL ch1_toggle_high: got %0d expected 6", hi); end
  endtask

  task automatic test_oneshot;
    logic [7:0] d;
    int first, cnt;
    do_reset();
    bus_wr(6'd0, 8'h05);
    bus_wr(6'd1, 8'h00);
    bus_wr(6'd4, 8'h0B);
    first = 0; cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (pb_out[0]) begin cnt++; if (first == 0) first = i; end
    end
    n_cmp++; if (first !== 6) begin n_bad++; $display("FAIL oneshot_latency: got %0d expected 6", first); end
    n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL oneshot_count: got %0d expected 1", cnt); end
    bus_rd(6'd4, d);
    n_cmp++; if (d !== 8'h0A) begin n_bad++; $display("FAIL oneshot_ctrl: got %h expected 0a", d); end
    bus_rd(6'd0, d);
    n_cmp++; if (d !== 8'h05) begin n_bad++; $display("FAIL oneshot_cnt_lo: got %h expected 05", d); end
    bus_rd(6'd1, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL oneshot_cnt_hi: got %h expected 00", d); end
    bus_rd(6'd16, d);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL oneshot_icr: got %h expected 01", d); end
  endtask

  task automatic test_cnt_src;
    logic [7:0] d;
    int first;
    do_reset();
    bus_wr(6'd0, 8'h02);
    bus_wr(6'd1, 8'h00);
    bus_wr(6'd4, 8'h23);
    cnt_in = 1'b1; step(4); cnt_in = 1'b0; step(4);
    bus_rd(6'd0, d);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL cnt_edge1: got %h expected 01", d); end
    step(10);
    bus_rd(6'd0, d);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL cnt_static: got %h expected 01", d); end
    cnt_in = 1'b1; step(4); cnt_in = 1'b0; step(4);
    bus_rd(6'd0, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL cnt_edge2: got %h expected 00", d); end
    cnt_in = 1'b1;
    first = 0;
    for (int i = 1; i <= 6; i++) begin step(1); if (pb_out[0] && first == 0) first = i; end
    n_cmp++; if (first !== 3) begin n_bad++; $display("FAIL cnt_uf_latency: got %0d expected 3", first); end
    cnt_in = 1'b0; step(4);
    bus_rd(6'd0, d);
    n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL cnt_reload: got %h expected 02", d); end
  endtask

  task automatic test_icr_race;
    logic [7:0] d;
    do_reset();
    bus_wr(6'd0, 8'h03);
    bus_wr(6'd1, 8'h00);
    bus_wr(6'd16, 8'h81);
    bus_wr(6'd4, 8'h01);
    step(3);
    bus_rd(6'd16, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL race_icr_value: got %h expected 00", d); end
    n_cmp++; if (irq_n !== 1'b1) begin n_bad++; $display("FAIL race_irq_n_read_edge: got %b expected 1", irq_n); end
    step(1);
    n_cmp++; if (irq_n !== 1'b0) begin n_bad++; $display("FAIL race_irq_n_reassert: got %b expected 0", irq_n); end
    bus_rd(6'd16, d);
    n_cmp++; if (d !== 8'h81) begin n_bad++; $display("FAIL race_flag_kept: got %h expected 81", d); end
    step(1);
    bus_wr(6'd4, 8'h11);
    bus_rd(6'd0, d);
    n_cmp++; if (d !== 8'h03) begin n_bad++; $display("FAIL fload_counter: got %h expected 03", d); end
    bus_rd(6'd16, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL fload_no_flag: got %h expected 00", d); end
    n_cmp++; if (irq_n !== 1'b1) begin n_bad++; $display("FAIL fload_irq_n: got %b expected 1", irq_n); end
    bus_rd(6'd4, d);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL fload_ctrl_load_bit: got %h expected 01", d); end
  endtask

  task automatic test_snapshot;
    logic [7:0] d;
    logic [7:0] exp_hi;
`ifdef CIA_TMR_SNAPSHOT_EN
    exp_hi = 8'h01;
`else
    exp_hi = 8'h00;
`endif
    do_reset();
    bus_wr(6'd0, 8'h02);
    bus_wr(6'd1, 8'h01);
    bus_wr(6'd4, 8'h01);
    step(2);
    bus_rd(6'd0, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL snap_byte0: got %h expected 00", d); end
    step(1);
    bus_rd(6'd1, d);
    n_cmp++; if (d !== exp_hi) begin n_bad++; $display("FAIL snap_byte1: got %h expected %h", d, exp_hi); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    do_reset();
    bus_wr(6'd0, 8'h03);
    bus_wr(6'd1, 8'h00);
    bus_wr(6'd16, 8'h81);
    bus_wr(6'd4, 8'h07);
    n_cmp++; if (pb_out[0] !== 1'b1) begin n_bad++; $display("FAIL start_sets_toggle: got %b expected 1", pb_out[0]); end
    step(10);
    n_cmp++; if (irq_n !== 1'b0) begin n_bad++; $display("FAIL mid_irq_active: got %b expected 0", irq_n); end
    res = 1'b1;
    #1;
    n_cmp++; if (pb_out !== 2'b00) begin n_bad++; $display("FAIL mid_rst_pb_out: got %b expected 00", pb_out); end
    n_cmp++; if (irq_n !== 1'b1) begin n_bad++; $display("FAIL mid_rst_irq_n: got %b expected 1", irq_n); end
    step(1);
    res = 1'b0;
    bus_wr(6'd4, 8'h10);
    bus_rd(6'd0, d);
    n_cmp++; if (d !== 8'hFF) begin n_bad++; $display("FAIL rst_latch_lo: got %h expected ff", d); end
    bus_rd(6'd1, d);
    n_cmp++; if (d !== 8'hFF) begin n_bad++; $display("FAIL rst_latch_hi: got %h expected ff", d); end
    bus_rd(6'd4, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL mid_rst_ctrl: got %h expected 00", d); end
    bus_rd(6'd16, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL mid_rst_icr: got %h expected 00", d); end
  endtask

  initial begin
    res = 1'b1; cs_n = 1'b1; rw = 1'b0; rs = '0; db_in = '0; cnt_in = 1'b0;
    test_reset();
    test_periodic_irq();
    test_cascade();
    test_oneshot();
    test_cnt_src();
    test_icr_race();
    test_snapshot();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cia_timer_array.md
Name: cia_timer_array

Overview:
- Parametrised successor to the CIA interval timers: CHANNELS independent WIDTH-bit down-counters sharing one bus port and one interrupt control register.
- Adds per-channel source selection, including cascade from the previous channel's underflow.
- Sits beside the CIA core on the same chip-select/rs bus and drives per-channel PB-style outputs plus a single irq_n.

Parameters:
- CHANNELS, 2: number of timers, legal 1..7.
- WIDTH, 16: counter width in bits, legal 8, 16, 24 or 32.
- ADDR_W, 6: rs width; must satisfy 2^ADDR_W > CHANNELS*8.

Ports:
- clk, input, 1: system clock, all state on posedge.
- res, input, 1: asynchronous active-high reset.
- cs_n, input, 1: chip select, active low.
- rw, input, 1: 1 = write, 0 = read; codebase bus convention.
- rs, input, ADDR_W: register select.
- db_in, input, 8: write data.
- db_out, output, 8: registered read data.
- cnt_in, input, 1: external count pin, asynchronous.
- pb_out, output, CHANNELS: per-channel timer output.
- irq_n, output, 1: interrupt request, active low.

Behaviour:
- Register map, channel c base = c*8:
  - Offsets 0..WIDTH/8-1: write = latch byte k; read = counter byte k.
  - Offset 4: CTRL.
  - Offsets 5..7 and unused byte offsets: read 0, writes ignored.
  - ICR at address CHANNELS*8; all other addresses read 0.
- CTRL bits:
  - [0] START.
  - [1] PBON.
  - [2] TOGGLE (1) / PULSE (0).
  - [3] ONESHOT.
  - [4] LOAD: strobe, always reads 0.
  - [6:5] SRC:
    - 00 = every clk.
    - 01 = cnt_in rising edge.
    - 10 = underflow of channel c-1.
    - 11 = underflow of c-1 while cnt_in is high.
    - Channel 0 treats SRC 10/11 as 00/01.
  - [7] reserved, reads 0.
- Reset values:
  - Latches all ones, counters 0, CTRL 0, IMR 0, ICR flags 0, toggle flops 0.
  - db_out 0, pb_out 0, irq_n 1.
- cnt_in handling: two-flop synchroniser, then edge detect; rising-edge tick is one clk wide, 3 clk after the pin edge.
- tick(c): START=1 and the selected source is active this cycle.
- On tick with counter != 0: counter decrements.
- On tick with counter == 0: underflow(c) pulses for 1 cycle, counter reloads from latch, ICR flag c sets, toggle flop inverts.
  - If ONESHOT=1, START clears in the same cycle.
  - Period = latch+1 ticks.
- Cascade: underflow(c-1) is combinational from channel c-1's tick and zero test. A chain of underflows resolves in one cycle.
- Force load:
  - Writing CTRL with bit4=1 loads the counter from the latch on that edge.
  - Force load overrides a coincident tick: no decrement, no underflow.
- Most-significant latch byte write with START=0 also loads the counter from {new byte, other latch bytes}.
- Writing CTRL with START going 0->1 sets the toggle flop to 1.
- pb_out[c]:
  - PBON=0 gives 0.
  - TOGGLE gives the toggle flop.
  - PULSE gives a registered copy of underflow(c), 1 clk wide.
- ICR write: bit7=1 ORs db_in[CHANNELS-1:0] into IMR; bit7=0 clears those IMR bits.
- ICR read:
  - Returns {irq, 0.., flags[CHANNELS-1:0]}.
  - Clears all flags and sets irq_n to 1 on the same edge.
  - An underflow coincident with the read-clear leaves its flag set.
  - irq_n asserts on the following edge if that flag is unmasked.
- irq_n is registered: it goes 0 one clk after any (flag & IMR) becomes nonzero and stays 0 until an ICR read.
- Reads:
  - db_out loads on the clk edge where cs_n=0 and rw=0; otherwise db_out loads 0.
  - Read side effects occur on that same edge.
- Reset asserted mid-operation returns everything to its reset values immediately, with no pending-load state retained.

Optional Feature:
- Macro: CIA_TMR_SNAPSHOT_EN.
- Defined: reading counter byte 0 of channel c captures the full counter into a per-channel snapshot register. Reads of bytes 1..WIDTH/8-1 return the snapshot, giving a tear-free multi-byte read. The snapshot is reset to 0.
- Undefined: every byte read returns the live counter byte.

Test Plan:
- Ch0 latch=0x0003, CTRL=0x01 (SRC clk) -> underflow every 4 clk. ICR bit0 sets; with IMR=0x81, irq_n goes 0 one clk later. ICR read returns 0x81, then irq_n=1 and a reread returns 0x00.
- Ch0 latch=0x0001 continuous; ch1 latch=0x0002, CTRL=0x41 (SRC 10) -> ch1 underflows every 6 clk. Ch1 PULSE pb_out[1] is 1 clk high; with TOGGLE and PBON, pb_out[1] has a 12-clk period.
- Ch0 latch=0x0005, CTRL=0x09 (one-shot) -> exactly one underflow after 6 clk. CTRL then reads 0x08 and the counter holds 0x0005.
- SRC 01, latch=0x0002, 3 cnt_in pulses -> underflow on the 3rd rising edge + 3 clk; no ticks while cnt_in is static.
- ICR read on the exact cycle of a ch0 underflow with IMR bit0 set -> returned flag is 0 (pre-clear), the flag remains 1 and irq_n re-asserts next clk. Force load coincident with underflow -> counter = latch, flag not set.
- SNAPSHOT_EN, WIDTH=16, counter at 0x0100 counting -> read byte0 = 0x00, read byte1 two clk later = 0x01 (snapshot). Without the macro, the same sequence returns 0x00.
